// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter funnelling NUM_REQ word streams into one FIFO write port, up to MAX_BURST words per grant.
// One cycle valid-to-grant; a full FIFO stalls the burst without timeout, and a dropped valid ends it.
module fifo_write_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_BURST  = 4
) (
    input  logic                          Clk_In,
    input  logic                          Reset_In,
    input  logic [NUM_REQ-1:0]            Req_Valid_In,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] Req_Data_In,
    output logic [NUM_REQ-1:0]            Req_Ready_Out,
    output logic [DATA_WIDTH-1:0]         FIFO_Data_Out,
    output logic                          FIFO_Write_Enable_Out,
    input  logic                          FIFO_Full_In,
    output logic [NUM_REQ-1:0]            Grant_Out,
    output logic                          Busy_Out,
    output logic [15:0]                   Write_Count_Out
);

    localparam int IDXW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNTW = $clog2(MAX_BURST + 1);

    typedef enum logic {IDLE, BURST} state_t;

    state_t              state_q, state_d;
    logic [IDXW-1:0]     gidx_q, gidx_d;
    logic [NUM_REQ-1:0]  grant_q, grant_d;
    logic [IDXW-1:0]     ptr_q, ptr_d;
    logic [CNTW-1:0]     cnt_q, cnt_d;
    logic [15:0]         wcnt_q, wcnt_d;

    logic                found;
    logic [IDXW-1:0]     sel;
    logic [IDXW:0]       idx;
    logic                g_vld;
    logic                xfer;

    // Search upward from the pointer; one extra index bit absorbs the wrap.
    always_comb begin
        found = 1'b0;
        sel   = '0;
        idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = {1'b0, ptr_q} + (IDXW+1)'(k);
            if (idx >= (IDXW+1)'(NUM_REQ)) begin
                idx = idx - (IDXW+1)'(NUM_REQ);
            end
            if (!found && Req_Valid_In[idx[IDXW-1:0]]) begin
                found = 1'b1;
                sel   = idx[IDXW-1:0];
            end
        end
    end

    always_comb begin
        g_vld                 = Req_Valid_In[gidx_q];
        xfer                  = (state_q == BURST) && g_vld && !FIFO_Full_In;
        FIFO_Write_Enable_Out = xfer;
        Req_Ready_Out         = '0;
        FIFO_Data_Out         = '0;
        if (state_q == BURST) begin
            if (!FIFO_Full_In) begin
                Req_Ready_Out = grant_q;
            end
            for (int i = 0; i < NUM_REQ; i++) begin
                if (gidx_q == IDXW'(i)) begin
                    FIFO_Data_Out = Req_Data_In[i*DATA_WIDTH +: DATA_WIDTH];
                end
            end
        end
        Grant_Out       = grant_q;
        Busy_Out        = (state_q == BURST);
        Write_Count_Out = wcnt_q;
    end

    always_comb begin
        state_d = state_q;
        gidx_d  = gidx_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        wcnt_d  = wcnt_q;
        case (state_q)
            IDLE: begin
                if (found) begin
                    state_d = BURST;
                    gidx_d  = sel;
                    grant_d = NUM_REQ'(1) << sel;
                    cnt_d   = '0;
                end
            end
            BURST: begin
                if (xfer) begin
                    cnt_d  = cnt_q + 1'b1;
                    wcnt_d = wcnt_q + 16'd1;
                end
                if ((xfer && cnt_q == CNTW'(MAX_BURST - 1)) || !g_vld) begin
                    state_d = IDLE;
                    grant_d = '0;
                    ptr_d   = (gidx_q == IDXW'(NUM_REQ - 1)) ? '0 : gidx_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk_In or posedge Reset_In) begin
        if (Reset_In) begin
            state_q <= IDLE;
            gidx_q  <= '0;
            grant_q <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
            wcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            gidx_q  <= gidx_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            wcnt_q  <= wcnt_d;
        end
    end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Directed bench for fifo_write_arbiter (4 requesters, 32-bit, bursts of 4) with a depth-8 FIFO model.
module tb_fifo_write_arbiter;

    logic         Clk_In;
    logic         Reset_In;
    logic [3:0]   Req_Valid_In;
    logic [127:0] Req_Data_In;
    logic [3:0]   Req_Ready_Out;
    logic [31:0]  FIFO_Data_Out;
    logic         FIFO_Write_Enable_Out;
    logic         FIFO_Full_In;
    logic [3:0]   Grant_Out;
    logic         Busy_Out;
    logic [15:0]  Write_Count_Out;

    int n_assert;
    int n_fail;

    int          sent [3];
    int          quota [3];
    logic [31:0] fq [$];
    logic        bad_wen;
    logic [31:0] rd;
    logic [31:0] exp_words [8];
    int          order [5];

    fifo_write_arbiter #(.NUM_REQ(4), .DATA_WIDTH(32), .MAX_BURST(4)) dut (
        .Clk_In               (Clk_In),
        .Reset_In             (Reset_In),
        .Req_Valid_In         (Req_Valid_In),
        .Req_Data_In          (Req_Data_In),
        .Req_Ready_Out        (Req_Ready_Out),
        .FIFO_Data_Out        (FIFO_Data_Out),
        .FIFO_Write_Enable_Out(FIFO_Write_Enable_Out),
        .FIFO_Full_In         (FIFO_Full_In),
        .Grant_Out            (Grant_Out),
        .Busy_Out             (Busy_Out),
        .Write_Count_Out      (Write_Count_Out)
    );

    initial Clk_In = 1'b0;
    always #5 Clk_In = ~Clk_In;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_static_data();
        for (int i = 0; i < 4; i++) Req_Data_In[i*32 +: 32] = 32'hDA7A_0000 + 32'(i);
    endtask

    // One clock cycle: drive at the falling edge, then check the outputs that cycle presents.
    task automatic cyc(input string tag, input logic [3:0] vld, input logic full,
                       input logic [3:0] eg, input logic ewen, input logic ebusy);
        logic [31:0] exp_d;
        logic [3:0]  exp_rdy;
        @(negedge Clk_In);
        Req_Valid_In = vld;
        FIFO_Full_In = full;
        #1;
        exp_d = '0;
        if (ebusy) begin
            for (int i = 0; i < 4; i++) if (eg[i]) exp_d = 32'hDA7A_0000 + 32'(i);
        end
        exp_rdy = (ebusy && !full) ? eg : 4'b0000;
        check({tag, "_grant"}, 32'(Grant_Out), 32'(eg));
        check({tag, "_wen"},   32'(FIFO_Write_Enable_Out), 32'(ewen));
        check({tag, "_busy"},  32'(Busy_Out), 32'(ebusy));
        check({tag, "_rdy"},   32'(Req_Ready_Out), 32'(exp_rdy));
        check({tag, "_data"},  FIFO_Data_Out, exp_d);
    endtask

    task automatic do_reset();
        @(negedge Clk_In);
        Req_Valid_In = '0;
        FIFO_Full_In = 1'b0;
        Reset_In     = 1'b1;
        @(negedge Clk_In);
        Reset_In     = 1'b0;
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        exp_words = '{32'hE000_0000, 32'hE000_0001, 32'hE000_0002, 32'hE000_0100,
                      32'hE000_0101, 32'hE000_0102, 32'hE000_0200, 32'hE000_0201};
        order = '{0, 1, 2, 3, 0};
        Reset_In     = 1'b1;
        Req_Valid_In = '0;
        FIFO_Full_In = 1'b0;
        set_static_data();
        #2;
        check("rst_grant", 32'(Grant_Out), 32'h0);
        check("rst_busy",  32'(Busy_Out), 32'h0);
        check("rst_wen",   32'(FIFO_Write_Enable_Out), 32'h0);
        check("rst_wcnt",  32'(Write_Count_Out), 32'h0);
        @(negedge Clk_In);
        Reset_In = 1'b0;

        // Single requester, 6 words: burst of 4, idle gap, regrant, 2 words, drop.
        cyc("r30_arb", 4'b0001, 1'b0, 4'b0000, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) cyc("r30_b1", 4'b0001, 1'b0, 4'b0001, 1'b1, 1'b1);
        cyc("r30_gap", 4'b0001, 1'b0, 4'b0000, 1'b0, 1'b0);
        for (int i = 0; i < 2; i++) cyc("r30_b2", 4'b0001, 1'b0, 4'b0001, 1'b1, 1'b1);
        cyc("r30_drop", 4'b0000, 1'b0, 4'b0001, 1'b0, 1'b1);
        cyc("r30_end",  4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0);
        check("r30_wcnt", 32'(Write_Count_Out), 32'd6);

        // All requesters valid: rotation 0,1,2,3,0 with one idle cycle between bursts.
        do_reset();
        for (int b = 0; b < 5; b++) begin
            cyc("r31_gap", 4'b1111, 1'b0, 4'b0000, 1'b0, 1'b0);
            for (int i = 0; i < 4; i++)
                cyc("r31_burst", 4'b1111, 1'b0, 4'(1 << order[b]), 1'b1, 1'b1);
        end
        cyc("r31_end", 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0);
        check("r31_wcnt", 32'(Write_Count_Out), 32'd20);

        // Grantee 2 stalled by a full FIFO for 3 cycles.
        do_reset();
        cyc("r32_arb", 4'b0100, 1'b0, 4'b0000, 1'b0, 1'b0);
        cyc("r32_w1",  4'b0100, 1'b0, 4'b0100, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) cyc("r32_full", 4'b0100, 1'b1, 4'b0100, 1'b0, 1'b1);
        check("r32_wcnt_stall", 32'(Write_Count_Out), 32'd1);
        for (int i = 0; i < 3; i++) cyc("r32_resume", 4'b0100, 1'b0, 4'b0100, 1'b1, 1'b1);
        cyc("r32_end", 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0);
        check("r32_wcnt", 32'(Write_Count_Out), 32'd4);

        // Grantee 1 drops after 2 words; requester 3 then wins.
        do_reset();
        cyc("r33_arb",  4'b0010, 1'b0, 4'b0000, 1'b0, 1'b0);
        for (int i = 0; i < 2; i++) cyc("r33_w", 4'b0010, 1'b0, 4'b0010, 1'b1, 1'b1);
        cyc("r33_drop", 4'b0000, 1'b0, 4'b0010, 1'b0, 1'b1);
        cyc("r33_idle", 4'b1000, 1'b0, 4'b0000, 1'b0, 1'b0);
        cyc("r33_g3",   4'b1000, 1'b0, 4'b1000, 1'b1, 1'b1);

        // Asynchronous reset in the middle of that burst, between edges.
        #2;
        Reset_In = 1'b1;
        #1;
        check("r34_grant", 32'(Grant_Out), 32'h0);
        check("r34_busy",  32'(Busy_Out), 32'h0);
        check("r34_wen",   32'(FIFO_Write_Enable_Out), 32'h0);
        check("r34_rdy",   32'(Req_Ready_Out), 32'h0);
        check("r34_data",  FIFO_Data_Out, 32'h0);
        check("r34_wcnt",  32'(Write_Count_Out), 32'h0);
        @(negedge Clk_In);
        Req_Valid_In = '0;
        Reset_In     = 1'b0;
        cyc("r29_arb", 4'b1111, 1'b0, 4'b0000, 1'b0, 1'b0);
        cyc("r29_g0",  4'b1111, 1'b0, 4'b0001, 1'b1, 1'b1);

        // End to end into a depth-8 FIFO: 3 requesters, 8 tagged words.
        do_reset();
        quota   = '{3, 3, 2};
        sent    = '{0, 0, 0};
        bad_wen = 1'b0;
        for (int c = 0; c < 30; c++) begin
            @(negedge Clk_In);
            Req_Valid_In = '0;
            for (int r = 0; r < 3; r++) begin
                Req_Valid_In[r] = (sent[r] < quota[r]);
                Req_Data_In[r*32 +: 32] = 32'hE000_0000 | 32'(r << 8) | 32'(sent[r]);
            end
            FIFO_Full_In = (fq.size() >= 8);
            #1;
            if (FIFO_Write_Enable_Out) begin
                if (FIFO_Full_In) bad_wen = 1'b1;
                else fq.push_back(FIFO_Data_Out);
                for (int r = 0; r < 3; r++)
                    if (Req_Valid_In[r] && Req_Ready_Out[r]) sent[r]++;
            end
        end
        for (int r = 0; r < 3; r++) check("e2e_sent", 32'(sent[r]), 32'(quota[r]));
        check("e2e_fill",   32'(fq.size()), 32'd8);
        check("e2e_badwen", 32'(bad_wen), 32'd0);
        check("e2e_wcnt",   32'(Write_Count_Out), 32'd8);

        // FIFO now full: a new grantee must stall without writing.
        set_static_data();
        cyc("e2e_full_arb",  4'b0001, 1'b1, 4'b0000, 1'b0, 1'b0);
        cyc("e2e_full_hold", 4'b0001, 1'b1, 4'b0001, 1'b0, 1'b1);
        cyc("e2e_full_drop", 4'b0000, 1'b1, 4'b0001, 1'b0, 1'b1);
        cyc("e2e_full_end",  4'b0000, 1'b1, 4'b0000, 1'b0, 1'b0);
        check("e2e_wcnt_full", 32'(Write_Count_Out), 32'd8);

        for (int k = 0; k < 8; k++) begin
            rd = 32'hFFFF_FFFF;
            if (fq.size() > 0) rd = fq.pop_front();
            check("e2e_readback", rd, exp_words[k]);
        end
        check("e2e_empty", 32'(fq.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/fifo_write_arbiter.md
FIFO_WRITE_ARBITER -- requirements
Module: fifo_write_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_REQ, default 4, meaning the number of write requesters (2..8).
REQ-002 The block SHALL have parameter DATA_WIDTH, default 32, meaning the FIFO word width.
REQ-003 The block SHALL have parameter MAX_BURST, default 4, meaning the maximum consecutive words per grant (1..16).
REQ-004 The block SHALL have port Clk_In  input  1  single clock; all state updates on the rising edge.
REQ-005 The block SHALL have port Reset_In  input  1  reset; asynchronous and active-high.
REQ-006 The block SHALL have port Req_Valid_In  input  NUM_REQ  per-requester word-valid.
REQ-007 The block SHALL have port Req_Data_In  input  NUM_REQ*DATA_WIDTH  requester i data in bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-008 The block SHALL have port Req_Ready_Out  output  NUM_REQ  per-requester word-accepted qualifier.
REQ-009 The block SHALL have port FIFO_Data_Out  output  DATA_WIDTH  data to the FIFO Data_In.
REQ-010 The block SHALL have port FIFO_Write_Enable_Out  output  1  drives the FIFO Write_Enable_In.
REQ-011 The block SHALL have port FIFO_Full_In  input  1  from the FIFO FIFO_Full.
REQ-012 The block SHALL have port Grant_Out  output  NUM_REQ  one-hot current grantee; all zero when idle.
REQ-013 The block SHALL have port Busy_Out  output  1  high while in state BURST.
REQ-014 The block SHALL have port Write_Count_Out  output  16  total words written since reset, wraps at 16'hFFFF -> 0.

Function
REQ-015 The block SHALL implement a two-state FSM: IDLE and BURST.
REQ-016 In IDLE with any Req_Valid_In bit high, the block SHALL select the first valid requester searching upward (with wrap) from the round-robin pointer, register it in Grant_Out, clear the burst counter, and enter BURST on the next edge.
REQ-017 In IDLE, Req_Ready_Out and FIFO_Write_Enable_Out SHALL be 0; arbitration latency is one cycle from valid to grant.
REQ-018 In BURST, Req_Ready_Out[g] SHALL equal !FIFO_Full_In for grantee g (combinational); all other ready bits SHALL be 0.
REQ-019 A transfer SHALL occur in a cycle where Req_Valid_In[g] and Req_Ready_Out[g] are both high; FIFO_Write_Enable_Out SHALL be high exactly in transfer cycles.
REQ-020 FIFO_Data_Out SHALL equal the grantee's data slice in BURST and all zeros in IDLE.
REQ-021 Each transfer SHALL increment the burst counter and Write_Count_Out by 1.
REQ-022 BURST SHALL return to IDLE on the edge after the MAX_BURST-th transfer, or after any cycle in which Req_Valid_In[g] is 0.
REQ-023 On leaving BURST, the pointer SHALL be set to (g+1) mod NUM_REQ and Grant_Out cleared.
REQ-024 While FIFO_Full_In is high and Req_Valid_In[g] is high, the block SHALL hold BURST with no transfer and no counter change (stall, no timeout).
REQ-025 A requester dropping valid during a full stall SHALL end the burst per REQ-022.
REQ-026 The block SHALL never assert FIFO_Write_Enable_Out while FIFO_Full_In is high.
REQ-027 Valid changes on non-granted requesters during BURST SHALL have no effect.

Reset
REQ-028 Reset_In high SHALL immediately force IDLE, pointer 0, burst counter 0, Grant_Out 0, Busy_Out 0, Write_Count_Out 0, and Req_Ready_Out, FIFO_Write_Enable_Out and FIFO_Data_Out to 0, including mid-burst.
REQ-029 After Reset_In falls, the first arbitration SHALL favour requester 0.

Verification
REQ-030 The bench SHALL cover: Req_Valid_In=4'b0001 for 6 words, FIFO not full -> grant 0, 4 writes, 1 IDLE cycle, regrant 0, 2 writes; Write_Count_Out=6.
REQ-031 The bench SHALL cover: Req_Valid_In=4'b1111 held -> grant order 0,1,2,3,0 with 4 writes each, one IDLE cycle between bursts.
REQ-032 The bench SHALL cover: grantee 2 writing, FIFO_Full_In high for 3 cycles -> FIFO_Write_Enable_Out=0, Grant_Out=4'b0100 held; writes resume when full falls.
REQ-033 The bench SHALL cover: grantee 1 drops valid after 2 words -> IDLE next edge, pointer=2; requester 3 alone valid -> grant 3.
REQ-034 The bench SHALL cover: Reset_In asserted mid-burst between clock edges -> all outputs 0 with no clock edge; Write_Count_Out=0.
REQ-035 The bench SHALL cover: end-to-end with the 32-bit FIFO (depth 8), 3 requesters writing 8 tagged words total -> FIFO_Full asserted; read-back order matches the arbiter write order with no loss or duplication.
